his_readout_fsm: RTL and testbench

Reads back the per-pixel histograms that the histogram builder accumulates in block RAM and streams them out one bin at a time over a valid/ready interface. A readout starts when the builder's toggle-encoded `nextFlag` changes level. The block reports the peak bin of each histogram and can optionally clear every bin after reading it. It sits between the histogram RAM read port and the downstream depth/peak processing.

---
 rtl/his_readout_if.sv | 29 ++
 rtl/his_readout_fsm.sv | 159 +++++++++++++++
 tb/tb_his_readout_fsm.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/his_readout_if.sv
// Histogram RAM read/clear port and bin output stream.
// Master side is the readout FSM, slave side is the RAM plus downstream sink.
interface his_readout_if #(
  parameter int NB    = 5,
  parameter int CNT_W = 16,
  parameter int PIX_W = 4
);
  logic [PIX_W+NB-1:0] memAddr;
  logic                memRdEn;
  logic [CNT_W-1:0]    memRdData;
  logic                memWrEn;
  logic                binValid;
  logic                binReady;
  logic [NB-1:0]       binIdx;
  logic [CNT_W-1:0]    binCount;
  logic                binLast;

  modport master (
    output memAddr, memRdEn, memWrEn,
    output binValid, binIdx, binCount, binLast,
    input  memRdData, binReady
  );

  modport slave (
    input  memAddr, memRdEn, memWrEn,
    input  binValid, binIdx, binCount, binLast,
    output memRdData, binReady
  );
endinterface

// File: rtl/his_readout_fsm.sv
// Streams per-pixel histograms out of RAM bin by bin and tracks the peak.
// Define HIS_CLEAR_EN to zero each bin in RAM after it is accepted.
module his_readout_fsm #(
  parameter int NB     = 5,
  parameter int CNT_W  = 16,
  parameter int PIX_W  = 4,
  parameter int PIXELS = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             nextFlag,
  his_readout_if.master    bus,
  output logic [NB-1:0]    peakIdx,
  output logic [CNT_W-1:0] peakCount,
  output logic             peakValid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [NB-1:0]    BIN_MAX = '1;
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
`ifdef HIS_CLEAR_EN
    S_CLR,
`endif
    S_ADV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             nf_q;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [NB-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0]    trk_idx_q, trk_idx_d;
  logic [CNT_W-1:0] trk_cnt_q, trk_cnt_d;
  logic [NB-1:0]    pk_idx_q, pk_idx_d;
  logic [CNT_W-1:0] pk_cnt_q, pk_cnt_d;
  logic             ovr_q, ovr_d;
  logic             start;

  assign start = (nextFlag != nf_q);

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= S_IDLE;
      nf_q      <= 1'b0;
      pix_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      trk_idx_q <= '0;
      trk_cnt_q <= '0;
      pk_idx_q  <= '0;
      pk_cnt_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nf_q      <= nextFlag;
      pix_q     <= pix_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      trk_idx_q <= trk_idx_d;
      trk_cnt_q <= trk_cnt_d;
      pk_idx_q  <= pk_idx_d;
      pk_cnt_q  <= pk_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_READ;
      S_READ: state_d = S_CAPT;
      S_CAPT: state_d = S_SEND;
`ifdef HIS_CLEAR_EN
      S_SEND: if (bus.binReady) state_d = S_CLR;
      S_CLR:  state_d = S_ADV;
`else
      S_SEND: if (bus.binReady) state_d = S_ADV;
`endif
      S_ADV:  state_d = (bin_q == BIN_MAX) ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_d     = pix_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    trk_idx_d = trk_idx_q;
    trk_cnt_d = trk_cnt_q;
    pk_idx_d  = pk_idx_q;
    pk_cnt_d  = pk_cnt_q;
    // Toggles outside IDLE are dropped but remembered.
    ovr_d     = ovr_q | (start && state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          trk_idx_d = '0;
          trk_cnt_d = '0;
        end
      end
      S_CAPT: begin
        cnt_d = bus.memRdData;
        // Strict compare keeps the lowest index on ties.
        if (bus.memRdData > trk_cnt_q) begin
          trk_idx_d = bin_q;
          trk_cnt_d = bus.memRdData;
        end
      end
      S_ADV: begin
        if (bin_q == BIN_MAX) begin
          pk_idx_d = trk_idx_q;
          pk_cnt_d = trk_cnt_q;
        end else begin
          bin_d = bin_q + NB'(1);
        end
      end
      S_DONE: begin
        pix_d = (pix_q == PIX_MAX) ? '0 : pix_q + PIX_W'(1);
        bin_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.memRdEn  = 1'b0;
    bus.memWrEn  = 1'b0;
    bus.binValid = 1'b0;
    peakValid    = 1'b0;
    busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_READ: bus.memRdEn  = 1'b1;
      S_SEND: bus.binValid = 1'b1;
`ifdef HIS_CLEAR_EN
      S_CLR:  bus.memWrEn  = 1'b1;
`endif
      S_DONE: peakValid    = 1'b1;
      default: ;
    endcase
  end

  assign bus.memAddr  = {pix_q, bin_q};
  assign bus.binIdx   = bin_q;
  assign bus.binCount = cnt_q;
  assign bus.binLast  = (bin_q == BIN_MAX);
  assign peakIdx      = pk_idx_q;
  assign peakCount    = pk_cnt_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_his_readout_fsm.sv
// Directed bench for his_readout_fsm with a RAM model and bin/peak scoreboards.
// Build with or without HIS_CLEAR_EN to match the design.
module tb_his_readout_fsm;

  localparam int NB     = 5;
  localparam int CNT_W  = 16;
  localparam int PIX_W  = 4;
  localparam int PIXELS = 16;
  localparam int NBINS  = 1 << NB;
  localparam int DEPTH  = 1 << (PIX_W + NB);
`ifdef HIS_CLEAR_EN
  localparam int PER = 5;
`else
  localparam int PER = 4;
`endif

  typedef struct packed {
    logic [NB-1:0]    idx;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } bin_t;

  typedef struct packed {
    logic [NB-1:0]    idx;
    logic [CNT_W-1:0] cnt;
  } pk_t;

  logic             clk = 1'b0;
  logic             res;
  logic             nextFlag;
  logic [NB-1:0]    peakIdx;
  logic [CNT_W-1:0] peakCount;
  logic             peakValid;
  logic             busy;
  logic             overrun;

  his_readout_if #(.NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

  his_readout_fsm #(
    .NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W), .PIXELS(PIXELS)
  ) dut (
    .clk       (clk),
    .res       (res),
    .nextFlag  (nextFlag),
    .bus       (bus),
    .peakIdx   (peakIdx),
    .peakCount (peakCount),
    .peakValid (peakValid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  logic [CNT_W-1:0] ram  [DEPTH];
  logic [CNT_W-1:0] snap [DEPTH];

  always @(posedge clk) begin
    if (bus.memRdEn) bus.memRdData <= ram[bus.memAddr];
    if (bus.memWrEn) ram[bus.memAddr] <= '0;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;
  int   wr_cnt   = 0;
  int   peaks_seen = 0;
  bin_t sb [$];
  pk_t  pk_q [$];
  bit   bp_en = 1'b0;
  logic [PIX_W-1:0] exp_pix = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.binReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.binReady = bp_en ? ~bus.binReady : 1'b1;
    end
  end

  // Output monitor: bin scoreboard, stall stability, peak scoreboard.
  bit   stalled = 1'b0;
  bin_t held;
  always @(negedge clk) begin
    if (res !== 1'b1) begin
      stalled = 1'b0;
    end else begin
      chk("rd_wr_exclusive", 32'(bus.memRdEn & bus.memWrEn), 0);
      if (bus.memRdEn) rd_cnt++;
      if (bus.memWrEn) wr_cnt++;
      if (bus.binValid) begin
        if (stalled) begin
          chk("hold_idx", 32'(bus.binIdx), 32'(held.idx));
          chk("hold_cnt", 32'(bus.binCount), 32'(held.cnt));
          chk("hold_last", 32'(bus.binLast), 32'(held.last));
        end
        if (bus.binReady) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            chk("bin_unexpected", 1, 0);
          end else begin
            bin_t e;
            e = sb.pop_front();
            chk("bin_idx", 32'(bus.binIdx), 32'(e.idx));
            chk("bin_cnt", 32'(bus.binCount), 32'(e.cnt));
            chk("bin_last", 32'(bus.binLast), 32'(e.last));
          end
        end else begin
          stalled   = 1'b1;
          held.idx  = bus.binIdx;
          held.cnt  = bus.binCount;
          held.last = bus.binLast;
        end
      end else begin
        stalled = 1'b0;
      end
      if (peakValid) begin
        peaks_seen++;
        if (pk_q.size() == 0) begin
          chk("peak_unexpected", 1, 0);
        end else begin
          pk_t p;
          p = pk_q.pop_front();
          chk("peak_idx", 32'(peakIdx), 32'(p.idx));
          chk("peak_cnt", 32'(peakCount), 32'(p.cnt));
        end
      end
    end
  end

  task automatic push_expected();
    logic [NB-1:0]       pi;
    logic [CNT_W-1:0]    pc;
    logic [PIX_W+NB-1:0] a;
    bin_t                e;
    pk_t                 p;
    pi = '0;
    pc = '0;
    for (int k = 0; k < NBINS; k++) begin
      a      = {exp_pix, NB'(k)};
      e.idx  = NB'(k);
      e.cnt  = ram[a];
      e.last = (k == NBINS - 1);
      sb.push_back(e);
      if (ram[a] > pc) begin
        pc = ram[a];
        pi = NB'(k);
      end
    end
    p.idx = pi;
    p.cnt = pc;
    pk_q.push_back(p);
  endtask

  task automatic run_readout(input bit timing, input bit dbl);
    int cyc;
    bit done;
    push_expected();
    nextFlag = ~nextFlag;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk("rd_start", 32'(bus.memRdEn), 1);
        chk("start_addr", 32'(bus.memAddr), 32'({exp_pix, NB'(0)}));
      end
      if (timing && cyc == 3) chk("first_valid", 32'(bus.binValid), 1);
      if (dbl && cyc == 10) nextFlag = ~nextFlag;
      if (peakValid) done = 1'b1;
    end
    chk("done_seen", 32'(done), 1);
    if (timing) chk("readout_cycles", cyc, 1 + NBINS * PER);
    @(posedge clk);
    #1;
    chk("idle_after_done", 32'(busy), 0);
    chk("sb_empty", sb.size(), 0);
    chk("pk_empty", pk_q.size(), 0);
    exp_pix = exp_pix + PIX_W'(1);
  endtask

  initial begin
    int cyc;
    int rd0;
    int pk0;
    int bad;
    bit found;

    for (int a = 0; a < DEPTH; a++) ram[a] = '0;
    res      = 1'b0;
    nextFlag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(bus.binValid), 0);
    chk("rst_rden", 32'(bus.memRdEn), 0);
    chk("rst_wren", 32'(bus.memWrEn), 0);
    chk("rst_addr", 32'(bus.memAddr), 0);
    chk("rst_binidx", 32'(bus.binIdx), 0);
    chk("rst_bincnt", 32'(bus.binCount), 0);
    chk("rst_peak", 32'({peakIdx, peakCount, peakValid}), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_no_access", rd_cnt + wr_cnt, 0);

    // Ramp histogram on pixel 0 with full-rate downstream.
    for (int k = 0; k < NBINS; k++) ram[k] = CNT_W'(k);
    run_readout(1'b1, 1'b0);

    // Tie on pixel 1 under backpressure.
    for (int k = 0; k < NBINS; k++) ram[NBINS + k] = '0;
    ram[NBINS + 3] = 16'd7;
    ram[NBINS + 9] = 16'd7;
    bp_en = 1'b1;
    run_readout(1'b0, 1'b0);
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Second toggle mid-readout is dropped.
    for (int k = 0; k < NBINS; k++) ram[2*NBINS + k] = CNT_W'($urandom_range(0, 65535));
    chk("overrun_pre", 32'(overrun), 0);
    pk0 = peaks_seen;
    run_readout(1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("overrun_set", 32'(overrun), 1);
    chk("one_readout", peaks_seen - pk0, 1);
    chk("overrun_idle", 32'(busy), 0);

    // Reset in the middle of pixel 3.
    for (int k = 0; k < NBINS; k++) ram[3*NBINS + k] = CNT_W'($urandom_range(1, 65535));
    push_expected();
    nextFlag = ~nextFlag;
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.binValid && bus.binIdx == NB'(12)) found = 1'b1;
    end
    chk("bin12_reached", 32'(found), 1);
    res      = 1'b0;
    nextFlag = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
    sb.delete();
    pk_q.delete();
    rd0 = rd_cnt;
    pk0 = peaks_seen;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    chk("mrst_addr", 32'(bus.memAddr), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_no_read", rd_cnt - rd0, 0);
    chk("mrst_no_peak", peaks_seen - pk0, 0);
    chk("mrst_rden", 32'(bus.memRdEn), 0);
    exp_pix = '0;

    // 17 readouts wrap the pixel counter back to 0.
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]  = CNT_W'($urandom_range(0, 65535));
      snap[a] = ram[a];
    end
    wr_cnt = 0;
    for (int r = 0; r < PIXELS + 1; r++) run_readout(1'b0, 1'b0);
    bad = 0;
`ifdef HIS_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== '0) bad++;
    chk("ram_cleared", bad, 0);
    chk("clear_writes", wr_cnt, (PIXELS + 1) * NBINS);
`else
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== snap[a]) bad++;
    chk("ram_preserved", bad, 0);
    chk("no_writes", wr_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
